term_stream_writer: RTL and testbench

- Drives the character terminal's write interface (data / dstrobe / dtype) from a byte stream with a valid/ready handshake.
- Turns ASCII text and control codes (CR, LF, BS, TAB, FF) into sequences of terminal strobes: char write, column write, row write.
- Sits between a byte source (UART receiver, CPU port) and the terminal, and is the terminal's only writer.
- Keeps a shadow cursor that mirrors the terminal's own cursor movement, so it needs no read-back.

---
 rtl/term_stream_writer.sv | 279 +++++++++++++++++++++++++++
 tb/tb_term_stream_writer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/term_stream_writer.sv
`default_nettype none
// ============================================================================
// Module      : term_stream_writer
// Description : Converts a valid/ready byte stream into character-terminal
//               write strobes (char / column / row). It keeps a shadow cursor
//               that mirrors the terminal's own cursor movement.
//               Optional macro TERM_WRITER_ESCPOS_EN enables ESC row/col
//               cursor positioning.
// Revision    : 1.0 - initial release
// ============================================================================
module term_stream_writer #(
    parameter int ROWS      = 30,
    parameter int COLS      = 80,
    parameter int INIT_ROW  = 15,
    parameter int INIT_COL  = 40,
    parameter int STROBE_HI = 4,
    parameter int STROBE_LO = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] data,
    output logic [1:0] dtype,
    output logic       dstrobe,
    output logic [4:0] shadow_row,
    output logic [6:0] shadow_col,
    output logic       busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_SETUP   = 3'd2;
    localparam logic [2:0] S_HIGH    = 3'd3;
    localparam logic [2:0] S_LOW     = 3'd4;
    localparam logic [2:0] S_ESC_ROW = 3'd5;
    localparam logic [2:0] S_ESC_COL = 3'd6;

    localparam logic [1:0]  c_T_CHAR    = 2'd0;
    localparam logic [1:0]  c_T_COL     = 2'd1;
    localparam logic [1:0]  c_T_ROW     = 2'd2;
    localparam logic [4:0]  c_ROW_MAX   = 5'(ROWS - 1);
    localparam logic [6:0]  c_COL_MAX   = 7'(COLS - 1);
    localparam logic [7:0]  c_ROW_MAX8  = 8'(ROWS - 1);
    localparam logic [7:0]  c_COL_MAX8  = 8'(COLS - 1);
    localparam logic [11:0] c_LAST_CELL = 12'(ROWS * COLS - 1);
    localparam logic [7:0]  c_HI_LAST   = 8'(STROBE_HI - 1);
    localparam logic [7:0]  c_LO_LAST   = 8'(STROBE_LO - 1);

    logic [2:0]  r_state, w_next;
    logic [7:0]  r_byte;
    logic [1:0]  r_op_type [0:3];
    logic [7:0]  r_op_data [0:3];
    logic [1:0]  r_op_last;
    logic [1:0]  r_op_idx;
    logic [7:0]  r_timer;
    logic [11:0] r_fill_cnt;
    logic        r_clear;
    logic        r_tail;
    logic [4:0]  r_row;
    logic [6:0]  r_col;
`ifdef TERM_WRITER_ESCPOS_EN
    logic [4:0]  r_esc_row;
`endif

    logic [1:0]  w_ld_type [0:3];
    logic [7:0]  w_ld_data [0:3];
    logic [1:0]  w_ld_last;
    logic        w_has_ops;
    logic        w_clear;
    logic        w_esc;
    logic [7:0]  w_col_dec;
    logic [7:0]  w_tab_raw;
    logic [7:0]  w_tab;
    logic [4:0]  w_row_inc;
    logic        w_seq_done;
    logic [1:0]  w_cur_type;
    logic [7:0]  w_cur_data;

    assign w_cur_type = r_op_type[r_op_idx];
    assign w_cur_data = r_op_data[r_op_idx];

    // A clear runs row0,col0,fill then loops back over row0,col0 as a tail
    assign w_seq_done = r_clear ? (r_tail && (r_op_idx == 2'd1))
                                : (r_op_idx == r_op_last);

    // Byte decode into an op list, evaluated against the current shadow cursor
    always_comb begin
        w_has_ops = 1'b0;
        w_clear   = 1'b0;
        w_esc     = 1'b0;
        w_ld_last = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_ld_type[i] = c_T_CHAR;
            w_ld_data[i] = 8'h00;
        end
        w_col_dec = {1'b0, r_col - 7'd1};
        w_tab_raw = ({1'b0, r_col} | 8'd7) + 8'd1;
        w_tab     = (w_tab_raw > c_COL_MAX8) ? c_COL_MAX8 : w_tab_raw;
        w_row_inc = (r_row == c_ROW_MAX) ? 5'd0 : r_row + 5'd1;
        case (r_byte)
            8'h0D: begin
                w_has_ops    = 1'b1;
                w_ld_type[0] = c_T_COL;
            end
            8'h0A: begin
                w_has_ops    = 1'b1;
                w_ld_type[0] = c_T_ROW;
                w_ld_data[0] = {3'b000, w_row_inc};
            end
            8'h08: begin
                if (r_col != 7'd0) begin
                    w_has_ops    = 1'b1;
                    w_ld_last    = 2'd2;
                    w_ld_type[0] = c_T_COL;
                    w_ld_data[0] = w_col_dec;
                    w_ld_type[1] = c_T_CHAR;
                    w_ld_data[1] = 8'h20;
                    w_ld_type[2] = c_T_COL;
                    w_ld_data[2] = w_col_dec;
                end
            end
            8'h09: begin
                w_has_ops    = 1'b1;
                w_ld_type[0] = c_T_COL;
                w_ld_data[0] = w_tab;
            end
            8'h0C: begin
                w_has_ops    = 1'b1;
                w_clear      = 1'b1;
                w_ld_last    = 2'd2;
                w_ld_type[0] = c_T_ROW;
                w_ld_type[1] = c_T_COL;
                w_ld_type[2] = c_T_CHAR;
                w_ld_data[2] = 8'h20;
            end
`ifdef TERM_WRITER_ESCPOS_EN
            8'h1B: w_esc = 1'b1;
`endif
            default: begin
                if (r_byte >= 8'h20 && r_byte != 8'h7F) begin
                    w_has_ops    = 1'b1;
                    w_ld_data[0] = r_byte;
                end
            end
        endcase
    end

    // State register; async reset aborts any sequence and drops dstrobe at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (in_valid) w_next = S_DECODE;
            S_DECODE: begin
                if (w_esc)          w_next = S_ESC_ROW;
                else if (w_has_ops) w_next = S_SETUP;
                else                w_next = S_IDLE;
            end
`ifdef TERM_WRITER_ESCPOS_EN
            S_ESC_ROW: if (in_valid) w_next = S_ESC_COL;
            S_ESC_COL: if (in_valid) w_next = S_SETUP;
`endif
            S_SETUP:  w_next = S_HIGH;
            S_HIGH:   if (r_timer == c_HI_LAST) w_next = S_LOW;
            S_LOW:    if (r_timer == c_LO_LAST) w_next = w_seq_done ? S_IDLE : S_SETUP;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs: data/dtype follow the current op, whose index only moves into SETUP
    always_comb begin
        data     = w_cur_data;
        dtype    = w_cur_type;
        dstrobe  = (r_state == S_HIGH);
        in_ready = (r_state == S_IDLE) || (r_state == S_ESC_ROW) || (r_state == S_ESC_COL);
        busy     = !in_ready;
    end

    assign shadow_row = r_row;
    assign shadow_col = r_col;

    // Datapath: byte capture, op list, strobe timing, fill counter, shadow cursor
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byte     <= 8'h00;
            r_op_last  <= 2'd0;
            r_op_idx   <= 2'd0;
            r_timer    <= 8'd0;
            r_fill_cnt <= 12'd0;
            r_clear    <= 1'b0;
            r_tail     <= 1'b0;
            r_row      <= 5'(INIT_ROW);
            r_col      <= 7'(INIT_COL);
            for (int i = 0; i < 4; i++) begin
                r_op_type[i] <= c_T_CHAR;
                r_op_data[i] <= 8'h00;
            end
`ifdef TERM_WRITER_ESCPOS_EN
            r_esc_row  <= 5'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) r_byte <= in_data;
                S_DECODE: begin
                    if (w_has_ops) begin
                        for (int i = 0; i < 4; i++) begin
                            r_op_type[i] <= w_ld_type[i];
                            r_op_data[i] <= w_ld_data[i];
                        end
                        r_op_last  <= w_ld_last;
                        r_op_idx   <= 2'd0;
                        r_clear    <= w_clear;
                        r_tail     <= 1'b0;
                        r_fill_cnt <= 12'd0;
                    end
                end
`ifdef TERM_WRITER_ESCPOS_EN
                S_ESC_ROW: begin
                    if (in_valid)
                        r_esc_row <= (in_data > c_ROW_MAX8) ? c_ROW_MAX : in_data[4:0];
                end
                S_ESC_COL: begin
                    if (in_valid) begin
                        r_op_type[0] <= c_T_ROW;
                        r_op_data[0] <= {3'b000, r_esc_row};
                        r_op_type[1] <= c_T_COL;
                        r_op_data[1] <= (in_data > c_COL_MAX8) ? c_COL_MAX8 : in_data;
                        r_op_last    <= 2'd1;
                        r_op_idx     <= 2'd0;
                        r_clear      <= 1'b0;
                        r_tail       <= 1'b0;
                    end
                end
`endif
                S_SETUP: begin
                    r_timer <= 8'd0;
                    if (w_cur_type == c_T_CHAR) begin
                        if (r_col == c_COL_MAX) begin
                            r_col <= 7'd0;
                            r_row <= (r_row == c_ROW_MAX) ? 5'd0 : r_row + 5'd1;
                        end else begin
                            r_col <= r_col + 7'd1;
                        end
                    end else if (w_cur_type == c_T_COL) begin
                        r_col <= w_cur_data[6:0];
                    end else begin
                        r_row <= w_cur_data[4:0];
                    end
                end
                S_HIGH: r_timer <= (r_timer == c_HI_LAST) ? 8'd0 : r_timer + 8'd1;
                S_LOW: begin
                    r_timer <= r_timer + 8'd1;
                    if (r_timer == c_LO_LAST && !w_seq_done) begin
                        if (r_clear && r_op_idx == 2'd2) begin
                            if (r_fill_cnt != c_LAST_CELL) begin
                                r_fill_cnt <= r_fill_cnt + 12'd1;
                            end else begin
                                r_op_idx <= 2'd0;
                                r_tail   <= 1'b1;
                            end
                        end else begin
                            r_op_idx <= r_op_idx + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_term_stream_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_term_stream_writer
// Description : Self-checking bench for term_stream_writer. Expected strobes
//               are queued when a byte is issued; a monitor pops and compares
//               each dstrobe rise and checks strobe high/low widths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_term_stream_writer;

    typedef struct packed {
        logic [1:0] t;
        logic [7:0] d;
    } op_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data;
    logic [1:0] dtype;
    logic       dstrobe;
    logic [4:0] shadow_row;
    logic [6:0] shadow_col;
    logic       busy;

    term_stream_writer dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data       (data),
        .dtype      (dtype),
        .dstrobe    (dstrobe),
        .shadow_row (shadow_row),
        .shadow_col (shadow_col),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    op_t exp_q[$];
    int  strobe_cnt = 0;
    bit  abort_ok = 1'b0;
    int  m_row = 15;
    int  m_col = 40;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: compare every strobe against the scoreboard and check widths
    logic prev_s = 1'b0;
    int   hi_cnt = 0;
    int   lo_cnt = 100;
    always @(negedge clk) begin
        if (dstrobe && !prev_s) begin
            op_t e;
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual=(%0d,%02h) required=none", dtype, data);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_op", {dtype, data}, {e.t, e.d});
            end
            if (lo_cnt < 4) chk("strobe_low_gap", lo_cnt, 4);
            hi_cnt = 1;
        end else if (dstrobe) begin
            hi_cnt++;
        end else if (prev_s) begin
            if (!abort_ok) chk("strobe_high_width", hi_cnt, 4);
            lo_cnt = 1;
        end else begin
            lo_cnt++;
        end
        prev_s = dstrobe;
    end

    function automatic void expect_op(input logic [1:0] t, input logic [7:0] d);
        exp_q.push_back(op_t'({t, d}));
    endfunction

    // Reference behaviour for the simple bytes used to position the cursor
    function automatic void model(input logic [7:0] b);
        int tab;
        if (b == 8'h0D) begin
            m_col = 0;
            expect_op(2'd1, 8'd0);
        end else if (b == 8'h0A) begin
            m_row = (m_row == 29) ? 0 : m_row + 1;
            expect_op(2'd2, 8'(m_row));
        end else if (b == 8'h09) begin
            tab   = (m_col | 7) + 1;
            m_col = (tab > 79) ? 79 : tab;
            expect_op(2'd1, 8'(m_col));
        end else begin
            expect_op(2'd0, b);
            if (m_col == 79) begin
                m_col = 0;
                m_row = (m_row == 29) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
    endfunction

    // Issue one byte; lat counts cycles from the accept cycle until in_ready returns
    task automatic send(input logic [7:0] b, input bit junk, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 30000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("ready_wait_timeout", 0, 1);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        if (junk) begin
            in_data  = 8'h42;
            in_valid = 1'b1;
        end
        while (!in_ready && lat < 30000) begin
            if (junk && lat == 8) in_valid = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        if (!in_ready) chk("ready_return_timeout", 0, 1);
    endtask

    task automatic drive(input logic [7:0] b);
        int lat;
        model(b);
        send(b, 1'b0, lat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int sc;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dstrobe", dstrobe, 0);
        chk("reset_data", data, 0);
        chk("reset_dtype", dtype, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_row", shadow_row, 15);
        chk("reset_col", shadow_col, 40);
        @(negedge clk);
        reset = 1'b0;

        // 'A' with junk bytes offered while busy
        expect_op(2'd0, 8'h41);
        send(8'h41, 1'b1, lat);
        chk("A_busy_cycles", lat, 11);
        chk("A_row", shadow_row, 15);
        chk("A_col", shadow_col, 41);
        m_col = 41;

        // Move to row 29, col 79 then write 'Z' to wrap to 0,0
        repeat (14) drive(8'h0A);
        repeat (5) drive(8'h09);
        chk("pos_row", shadow_row, 29);
        chk("pos_col", shadow_col, 79);
        expect_op(2'd0, 8'h5A);
        send(8'h5A, 1'b0, lat);
        chk("Z_row", shadow_row, 0);
        chk("Z_col", shadow_col, 0);
        m_row = 0; m_col = 0;

        // Backspace at col 5 then at col 0
        drive(8'h0D);
        for (int i = 0; i < 5; i++) drive(8'h61 + 8'(i));
        chk("bs_pre_col", shadow_col, 5);
        expect_op(2'd1, 8'h04);
        expect_op(2'd0, 8'h20);
        expect_op(2'd1, 8'h04);
        send(8'h08, 1'b0, lat);
        chk("bs_col", shadow_col, 4);
        chk("bs_busy_cycles", lat, 2 + 3 * 9);
        m_col = 4;
        drive(8'h0D);
        sc = strobe_cnt;
        send(8'h08, 1'b0, lat);
        chk("bs0_busy_cycles", lat, 2);
        chk("bs0_col", shadow_col, 0);
        chk("bs0_strobes", strobe_cnt - sc, 0);

        // Form feed clears the whole screen
        expect_op(2'd2, 8'h00);
        expect_op(2'd1, 8'h00);
        for (int i = 0; i < 2400; i++) expect_op(2'd0, 8'h20);
        expect_op(2'd2, 8'h00);
        expect_op(2'd1, 8'h00);
        sc = strobe_cnt;
        send(8'h0C, 1'b0, lat);
        chk("ff_busy_cycles", lat, 2 + 2404 * 9);
        chk("ff_strobes", strobe_cnt - sc, 2404);
        chk("ff_row", shadow_row, 0);
        chk("ff_col", shadow_col, 0);
        m_row = 0; m_col = 0;

        // CR then LF at row 29
        repeat (29) drive(8'h0A);
        chk("lf_pre_row", shadow_row, 29);
        expect_op(2'd1, 8'h00);
        send(8'h0D, 1'b0, lat);
        expect_op(2'd2, 8'h00);
        send(8'h0A, 1'b0, lat);
        chk("lf_wrap_row", shadow_row, 0);
        chk("lf_col", shadow_col, 0);
        m_row = 0; m_col = 0;

        // TAB at col 78 clamps to 79; BEL is ignored
        repeat (9) drive(8'h09);
        for (int i = 0; i < 6; i++) drive(8'h30 + 8'(i));
        chk("tab_pre_col", shadow_col, 78);
        expect_op(2'd1, 8'd79);
        send(8'h09, 1'b0, lat);
        chk("tab_col", shadow_col, 79);
        m_col = 79;
        sc = strobe_cnt;
        send(8'h07, 1'b0, lat);
        chk("bel_busy_cycles", lat, 2);
        chk("bel_strobes", strobe_cnt - sc, 0);

        // Reset in the 2nd dstrobe-high cycle
        expect_op(2'd0, 8'h42);
        in_data  = 8'h42;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !dstrobe; i++) begin
            @(posedge clk); #1;
        end
        chk("abort_strobe_seen", dstrobe, 1);
        @(posedge clk); #2;
        abort_ok = 1'b1;
        reset    = 1'b1;
        #1;
        chk("abort_dstrobe", dstrobe, 0);
        chk("abort_row", shadow_row, 15);
        chk("abort_col", shadow_col, 40);
        chk("abort_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        abort_ok = 1'b0;
        m_row = 15; m_col = 40;

`ifdef TERM_WRITER_ESCPOS_EN
        send(8'h1B, 1'b0, lat);
        chk("esc_busy_cycles", lat, 2);
        send(8'd40, 1'b0, lat);
        chk("esc_row_cycles", lat, 1);
        expect_op(2'd2, 8'd29);
        expect_op(2'd1, 8'd79);
        send(8'd100, 1'b0, lat);
        chk("esc_row", shadow_row, 29);
        chk("esc_col", shadow_col, 79);
`else
        sc = strobe_cnt;
        send(8'h1B, 1'b0, lat);
        chk("esc_ignored_cycles", lat, 2);
        chk("esc_ignored_strobes", strobe_cnt - sc, 0);
        chk("esc_ignored_col", shadow_col, 40);
`endif

        repeat (20) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
